// File: rtl/mult_shift_add_if.sv
// Operand/result bundle between the operand mux/controller and the MAC unit.
// Signals: iniciar (start), a/b/c (N-bit operands), resultado (2N-bit result),
// pronto (completion pulse), ocupado (busy).
// master: controller side (drives start and operands); slave: the MAC unit.
`timescale 1ns/1ps
interface mult_shift_add_if #(
  parameter int unsigned N = 10
);
  logic               iniciar;
  logic [N-1:0]       a;
  logic [N-1:0]       b;
  logic [N-1:0]       c;
  logic [2*N-1:0]     resultado;
  logic               pronto;
  logic               ocupado;

  modport master (
    output iniciar, a, b, c,
    input  resultado, pronto, ocupado
  );

  modport slave (
    input  iniciar, a, b, c,
    output resultado, pronto, ocupado
  );
endinterface

// File: rtl/mult_shift_add.sv
// Sequential shift-and-add multiply-accumulate: resultado = a*b + c.
// Ports: clock, reset (async, active-high), bus (slave side of
// mult_shift_add_if carrying iniciar, a, b, c in and resultado, pronto,
// ocupado out). One bit of the multiplier is consumed per cycle, so a
// result appears N cycles after the start edge and is held until the next
// completion.
`timescale 1ns/1ps
module mult_shift_add #(
  parameter int unsigned N = 10
) (
  input  logic           clock,
  input  logic           reset,
  mult_shift_add_if.slave bus
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    resultado_q, resultado_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cont_q, cont_d;
  logic            pronto_q, pronto_d;
  logic            ocupado_q, ocupado_d;
  logic [W-1:0]    acc_sum;

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    resultado_d = resultado_q;
    mplier_d    = mplier_q;
    cont_d      = cont_q;
    // Carry-out is dropped: a*b + c never exceeds 2N bits.
    acc_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      OCIOSO: begin
        if (bus.iniciar) begin
          mcand_d  = {{N{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = {{N{1'b0}}, bus.c};
          cont_d   = '0;
          state_d  = CALCULA;
        end
      end
      CALCULA: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cont_d   = cont_q + CW'(1);
        // Last iteration publishes the sum including this cycle's add.
        if (cont_q == CW'(N - 1)) begin
          resultado_d = acc_sum;
          state_d     = FIM;
        end
      end
      FIM: begin
        state_d = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase

    // Flags are registered copies of the upcoming state's decode.
    pronto_d  = (state_d == FIM);
    ocupado_d = (state_d != OCIOSO);
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= OCIOSO;
      mcand_q     <= '0;
      acc_q       <= '0;
      resultado_q <= '0;
      mplier_q    <= '0;
      cont_q      <= '0;
      pronto_q    <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      resultado_q <= resultado_d;
      mplier_q    <= mplier_d;
      cont_q      <= cont_d;
      pronto_q    <= pronto_d;
      ocupado_q   <= ocupado_d;
    end
  end

  assign bus.resultado = resultado_q;
  assign bus.pronto    = pronto_q;
  assign bus.ocupado   = ocupado_q;

endmodule

// File: tb/tb_mult_shift_add.sv
// Self-checking bench for mult_shift_add: directed vector table, randomized
// operations against an arithmetic reference, and multi-cycle corner cases
// (operand stability, held start, reset mid-operation).
`timescale 1ns/1ps
module tb_mult_shift_add;

  localparam int unsigned N = 10;
  localparam int unsigned W = 2 * N;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  mult_shift_add_if #(.N(N)) bus ();

  mult_shift_add #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the captured operands.
  function automatic logic [W-1:0] ref_mac(input logic [N-1:0] a, b, c);
    logic [63:0] r;
    r = 64'(a) * 64'(b) + 64'(c);
    return W'(r);
  endfunction

  // One full operation; optionally scrambles operands while busy.
  task automatic run_op(input string name, input logic [N-1:0] a, b, c,
                        input logic [W-1:0] exp, input bit scramble);
    int           lat;
    int           busy;
    bit           found;
    logic [W-1:0] res;
    lat   = -1;
    busy  = 0;
    found = 1'b0;
    res   = '0;
    @(negedge clock);
    bus.a = a; bus.b = b; bus.c = c; bus.iniciar = 1'b1;
    @(posedge clock);                       // E0
    for (int k = 0; k <= 3 * int'(N) && !found; k++) begin
      @(negedge clock);                     // after E_k
      bus.iniciar = 1'b0;
      if (scramble) begin
        bus.a = N'($urandom);
        bus.b = N'($urandom);
        bus.c = N'($urandom);
      end
      if (bus.ocupado) busy++;
      if (bus.pronto) begin
        found = 1'b1;
        lat   = k;
        res   = bus.resultado;
      end
    end
    check({name, " resultado"}, 64'(res), 64'(exp));
    check({name, " latency"}, 64'(lat), 64'(N));
    check({name, " busy_cycles"}, 64'(busy), 64'(N + 1));
    @(negedge clock);                       // after E(N+1)
    check({name, " pronto_drop"}, 64'(bus.pronto), 64'(0));
    check({name, " ocupado_drop"}, 64'(bus.ocupado), 64'(0));
    check({name, " resultado_held"}, 64'(bus.resultado), 64'(exp));
  endtask

  vec_t vecs[7];
  int   pulses[$];
  int   pr_seen;
  bit   idle;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.iniciar = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0;

    vecs[0] = '{a: 10'd3,    b: 10'd5,    c: 10'd7,    exp: 20'd22};
    vecs[1] = '{a: 10'd1023, b: 10'd1023, c: 10'd1023, exp: 20'hFFC00};
    vecs[2] = '{a: 10'd0,    b: 10'd1023, c: 10'd9,    exp: 20'd9};
    vecs[3] = '{a: 10'd1,    b: 10'd1,    c: 10'd0,    exp: 20'd1};
    vecs[4] = '{a: 10'd0,    b: 10'd0,    c: 10'd0,    exp: 20'd0};
    vecs[5] = '{a: 10'd1023, b: 10'd0,    c: 10'd1023, exp: 20'd1023};
    vecs[6] = '{a: 10'd512,  b: 10'd512,  c: 10'd5,    exp: 20'd262149};

    #1;
    check("reset resultado", 64'(bus.resultado), 64'(0));
    check("reset pronto", 64'(bus.pronto), 64'(0));
    check("reset ocupado", 64'(bus.ocupado), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Directed vector table
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, 1'b0);

    // Operands changing every cycle while busy must not disturb the result
    run_op("stability", 10'd12, 10'd10, 10'd0, 20'd120, 1'b1);

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] ra, rb, rc;
      ra = N'($urandom);
      rb = N'($urandom);
      rc = N'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, rc, ref_mac(ra, rb, rc), i[0]);
    end

    // Held start: restarts only at E(N+2), so pulses every N+2 cycles
    @(negedge clock);
    bus.a = 10'd2; bus.b = 10'd2; bus.c = 10'd0; bus.iniciar = 1'b1;
    @(posedge clock);                       // E0
    pulses.delete();
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.pronto) begin
        pulses.push_back(k);
        check($sformatf("held_start resultado@%0d", k), 64'(bus.resultado), 64'(4));
      end
    end
    check("held_start pulse_count", 64'(pulses.size()), 64'(3));
    for (int i = 0; i < pulses.size() && i < 3; i++)
      check($sformatf("held_start pulse%0d_cycle", i), 64'(pulses[i]), 64'(N + i * (N + 2)));
    bus.iniciar = 1'b0;
    idle = 1'b0;
    for (int k = 0; k < 30 && !idle; k++) begin
      @(negedge clock);
      if (!bus.ocupado) idle = 1'b1;
    end
    check("held_start drain_idle", 64'(idle), 64'(1));

    // Reset landing on E5 of a running operation, asserted between edges
    @(negedge clock);
    bus.a = 10'd100; bus.b = 10'd100; bus.c = 10'd0; bus.iniciar = 1'b1;
    @(posedge clock);                       // E0
    @(negedge clock);
    bus.iniciar = 1'b0;
    check("midop ocupado_before", 64'(bus.ocupado), 64'(1));
    check("midop resultado_before", 64'(bus.resultado), 64'(4));
    repeat (4) @(posedge clock);            // E1..E4
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midop async resultado", 64'(bus.resultado), 64'(0));
    check("midop async ocupado", 64'(bus.ocupado), 64'(0));
    check("midop async pronto", 64'(bus.pronto), 64'(0));
    @(posedge clock);                       // E5 under reset
    @(negedge clock);
    reset = 1'b0;
    pr_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.pronto) pr_seen++;
    end
    check("midop no_pronto", 64'(pr_seen), 64'(0));
    check("midop resultado_zero", 64'(bus.resultado), 64'(0));
    check("midop ocupado_idle", 64'(bus.ocupado), 64'(0));
    run_op("after_reset", 10'd4, 10'd6, 10'd1, 20'd25, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
